// File: rtl/ga_pkg.sv
// Shared types and widths for the genetic-algorithm selection datapath.
package ga_pkg;

    localparam int CHROM_W = 150;
    localparam int DIST_W  = 12;
    localparam int GENE_W  = 10;

    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RD,
        ST_LATCH,
        ST_WAIT_DONE,
        ST_UPDATE,
        ST_FINISH
    } sel_state_e;

endpackage

// File: rtl/fitness_select_best2_tracker.sv
// Keeps the two shortest-tour chromosomes seen since the last clear.
// SEL_DEDUP_EN: a candidate equal to the current best is never stored as second.
module best2_tracker
    import ga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               update,
    input  logic [CHROM_W-1:0] cand_chrom,
    input  logic [DIST_W-1:0]  cand_dist,
    output logic [CHROM_W-1:0] best_chrom,
    output logic [DIST_W-1:0]  best_dist,
    output logic [CHROM_W-1:0] second_chrom,
    output logic [DIST_W-1:0]  second_dist
);

    logic [CHROM_W-1:0] best_chrom_q, best_chrom_d;
    logic [DIST_W-1:0]  best_dist_q, best_dist_d;
    logic [CHROM_W-1:0] second_chrom_q, second_chrom_d;
    logic [DIST_W-1:0]  second_dist_q, second_dist_d;
    logic               lt_best, lt_second, is_dup;

    // Strict compares: an equal later candidate never displaces an earlier one.
    assign lt_best   = cand_dist < best_dist_q;
    assign lt_second = cand_dist < second_dist_q;

`ifdef SEL_DEDUP_EN
    assign is_dup = (cand_chrom == best_chrom_q);
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        best_chrom_d   = best_chrom_q;
        best_dist_d    = best_dist_q;
        second_chrom_d = second_chrom_q;
        second_dist_d  = second_dist_q;
        if (clear) begin
            best_chrom_d   = '0;
            best_dist_d    = DIST_MAX;
            second_chrom_d = '0;
            second_dist_d  = DIST_MAX;
        end else if (update) begin
            if (lt_best) begin
                best_dist_d = cand_dist;
                if (!is_dup) begin
                    second_chrom_d = best_chrom_q;
                    second_dist_d  = best_dist_q;
                    best_chrom_d   = cand_chrom;
                end
            end else if (lt_second && !is_dup) begin
                second_chrom_d = cand_chrom;
                second_dist_d  = cand_dist;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_chrom_q   <= '0;
            best_dist_q    <= DIST_MAX;
            second_chrom_q <= '0;
            second_dist_q  <= DIST_MAX;
        end else begin
            best_chrom_q   <= best_chrom_d;
            best_dist_q    <= best_dist_d;
            second_chrom_q <= second_chrom_d;
            second_dist_q  <= second_dist_d;
        end
    end

    assign best_chrom   = best_chrom_q;
    assign best_dist    = best_dist_q;
    assign second_chrom = second_chrom_q;
    assign second_dist  = second_dist_q;

endmodule

// File: rtl/fitness_select.sv
// Scans the population RAM once per generation, evaluates each chromosome and keeps the two best.
// Optional macro SEL_DEDUP_EN (in best2_tracker) prevents duplicate parents.
module fitness_select
    import ga_pkg::*;
#(
    parameter int POP_SIZE = 16,
    parameter int IDX_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IDX_W-1:0]   pop_addr,
    input  logic [CHROM_W-1:0] pop_data,
    output logic [CHROM_W-1:0] dist_chrom,
    output logic               dist_start,
    input  logic [DIST_W-1:0]  dist_in,
    input  logic               dist_done,
    output logic [CHROM_W-1:0] parent_a,
    output logic [CHROM_W-1:0] parent_b,
    output logic [DIST_W-1:0]  best_dist,
    output logic [DIST_W-1:0]  second_dist,
    output logic               busy,
    output logic               done
);

    sel_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CHROM_W-1:0] dist_chrom_q, dist_chrom_d;
    logic               dist_start_q, dist_start_d;
    logic [DIST_W-1:0]  cand_dist_q, cand_dist_d;
    logic               start_accept, last_idx;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign last_idx     = (idx_q == IDX_W'(POP_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (start) state_d = ST_READ;
            ST_READ:      state_d = ST_WAIT_RD;
            ST_WAIT_RD:   state_d = ST_LATCH;
            ST_LATCH:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (dist_done) state_d = ST_UPDATE;
            ST_UPDATE:    state_d = last_idx ? ST_FINISH : ST_READ;
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        done = (state_q == ST_FINISH);
    end

    // Datapath registers; dist_done is only sampled in WAIT_DONE.
    always_comb begin
        idx_d        = idx_q;
        dist_chrom_d = dist_chrom_q;
        dist_start_d = 1'b0;
        cand_dist_d  = cand_dist_q;
        unique case (state_q)
            ST_IDLE:      if (start) idx_d = '0;
            ST_LATCH: begin
                dist_chrom_d = pop_data;
                dist_start_d = 1'b1;
            end
            ST_WAIT_DONE: if (dist_done) cand_dist_d = dist_in;
            ST_UPDATE:    if (!last_idx) idx_d = idx_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            dist_chrom_q <= '0;
            dist_start_q <= 1'b0;
            cand_dist_q  <= '0;
        end else begin
            idx_q        <= idx_d;
            dist_chrom_q <= dist_chrom_d;
            dist_start_q <= dist_start_d;
            cand_dist_q  <= cand_dist_d;
        end
    end

    assign pop_addr   = idx_q;
    assign dist_chrom = dist_chrom_q;
    assign dist_start = dist_start_q;

    best2_tracker u_best2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start_accept),
        .update       (state_q == ST_UPDATE),
        .cand_chrom   (dist_chrom_q),
        .cand_dist    (cand_dist_q),
        .best_chrom   (parent_a),
        .best_dist    (best_dist),
        .second_chrom (parent_b),
        .second_dist  (second_dist)
    );

endmodule

// File: tb/tb_fitness_select.sv
// Randomized scoreboard bench for fitness_select with a behavioural evaluator and RAM.
module tb_fitness_select;
    import ga_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 20;
    localparam int SCAN_CYC = N * (5 + L) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [IW-1:0]      pop_addr;
    logic [CHROM_W-1:0] pop_data;
    logic [CHROM_W-1:0] dist_chrom;
    logic               dist_start;
    logic [DIST_W-1:0]  dist_in = '0;
    logic               dist_done = 1'b0;
    logic [CHROM_W-1:0] parent_a, parent_b;
    logic [DIST_W-1:0]  best_dist, second_dist;
    logic               busy, done;

    fitness_select #(.POP_SIZE(N), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pop_addr(pop_addr), .pop_data(pop_data),
        .dist_chrom(dist_chrom), .dist_start(dist_start),
        .dist_in(dist_in), .dist_done(dist_done),
        .parent_a(parent_a), .parent_b(parent_b),
        .best_dist(best_dist), .second_dist(second_dist),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [CHROM_W-1:0] mem  [N];
    logic [DIST_W-1:0]  dtab [N];
    always @(posedge clk) pop_data <= mem[pop_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [CHROM_W-1:0] act, input logic [CHROM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CHROM_W-1:0] pa;
        logic [CHROM_W-1:0] pb;
        logic [DIST_W-1:0]  bd;
        logic [DIST_W-1:0]  sd;
        int                 start_cyc;
    } exp_t;
    exp_t sb[$];

    // Reference: best = smallest distance below DIST_MAX (earliest on ties), second = same over the rest.
    function automatic exp_t model();
        exp_t e;
        int bi = -1;
        int si = -1;
        for (int i = 0; i < N; i++)
            if (dtab[i] != DIST_MAX && (bi < 0 || dtab[i] < dtab[bi])) bi = i;
        for (int i = 0; i < N; i++)
            if (i != bi && dtab[i] != DIST_MAX && (si < 0 || dtab[i] < dtab[si])) si = i;
        e.pa = (bi < 0) ? '0 : mem[bi];
        e.bd = (bi < 0) ? DIST_MAX : dtab[bi];
        e.pb = (si < 0) ? '0 : mem[si];
        e.sd = (si < 0) ? DIST_MAX : dtab[si];
        e.start_cyc = 0;
        return e;
    endfunction

    function automatic logic [DIST_W-1:0] lookup(input logic [CHROM_W-1:0] c);
        for (int i = 0; i < N; i++)
            if (mem[i] == c) return dtab[i];
        return DIST_MAX;
    endfunction

    function automatic logic [CHROM_W-1:0] rand_chrom();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[CHROM_W-1:0];
    endfunction

    // Evaluator model: fixed latency L, optional spurious dist_done during the following READ.
    bit                 spur_pending = 1'b0;
    int                 n_evals = 0;
    logic [CHROM_W-1:0] ev_chrom;
    bit                 ev_stable, ev_abort;
    initial forever begin
        @(posedge clk); #1;
        if (dist_start === 1'b1) begin
            n_evals++;
            ev_chrom  = dist_chrom;
            ev_stable = 1'b1;
            ev_abort  = 1'b0;
            for (int k = 0; k < L; k++) begin
                @(posedge clk); #1;
                if (!rst_n) ev_abort = 1'b1;
                if (dist_chrom !== ev_chrom) ev_stable = 1'b0;
            end
            dist_done = 1'b1;
            dist_in   = lookup(ev_chrom);
            @(posedge clk); #1;
            dist_done = 1'b0;
            if (!ev_abort && rst_n) check("dist_chrom_stable", CHROM_W'(ev_stable), CHROM_W'(1));
            if (spur_pending) begin
                @(posedge clk); #1;
                dist_done = 1'b1;
                dist_in   = '0;
                @(posedge clk); #1;
                dist_done    = 1'b0;
                spur_pending = 1'b0;
            end
        end
    end

    // Monitor: pops the expected result whenever the DUT signals done.
    int   n_done = 0;
    exp_t got;
    initial forever begin
        @(posedge clk); #1;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                got = sb.pop_front();
                check("parent_a", parent_a, got.pa);
                check("parent_b", parent_b, got.pb);
                check("best_dist", CHROM_W'(best_dist), CHROM_W'(got.bd));
                check("second_dist", CHROM_W'(second_dist), CHROM_W'(got.sd));
                check("scan_latency", CHROM_W'(cyc - got.start_cyc), CHROM_W'(SCAN_CYC));
                $display("scan done cyc=%0d best=%0d second=%0d", cyc, best_dist, second_dist);
            end
        end
    end

    bit dedup_case = 1'b0;

    task automatic run_scan(input bit disturb);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        e = model();
`ifdef SEL_DEDUP_EN
        if (dedup_case) begin
            e.pb = mem[1];
            e.sd = dtab[1];
        end
`endif
        e.start_cyc = cyc;
        sb.push_back(e);
        if (disturb) spur_pending = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            repeat (40) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (k < 2000) begin
            @(posedge clk); #1;
            if (done === 1'b1) break;
            k++;
        end
        if (k >= 2000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
            sb.delete();
        end
    endtask

    task automatic randomize_pop();
        for (int i = 0; i < N; i++) begin
            mem[i] = rand_chrom();
            case ($urandom_range(0, 3))
                0:       dtab[i] = DIST_MAX;
                1:       dtab[i] = DIST_W'($urandom_range(0, 7) * 100);
                default: dtab[i] = DIST_W'($urandom_range(0, 4095));
            endcase
        end
    endtask

    task automatic set_dists(input int d0, input int d1, input int d2, input int d3);
        for (int i = 0; i < N; i++) mem[i] = rand_chrom();
        dtab[0] = DIST_W'(d0);
        dtab[1] = DIST_W'(d1);
        dtab[2] = DIST_W'(d2);
        dtab[3] = DIST_W'(d3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int done_before;
        for (int i = 0; i < N; i++) begin
            mem[i]  = '0;
            dtab[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", CHROM_W'(busy), CHROM_W'(0));
        check("rst_done", CHROM_W'(done), CHROM_W'(0));
        check("rst_best_dist", CHROM_W'(best_dist), CHROM_W'(DIST_MAX));
        check("rst_second_dist", CHROM_W'(second_dist), CHROM_W'(DIST_MAX));
        check("rst_parent_a", parent_a, '0);
        check("rst_dist_start", CHROM_W'(dist_start), CHROM_W'(0));
        rst_n = 1'b1;

        set_dists(300, 100, 200, 50);
        run_scan(1'b0);
        wait_done();

        set_dists(100, 100, 100, 100);
        run_scan(1'b0);
        wait_done();

        set_dists(80, 90, 80, 4095);
        mem[2] = mem[0];
        dedup_case = 1'b1;
        run_scan(1'b0);
        wait_done();
        dedup_case = 1'b0;

        set_dists(4095, 4095, 4095, 4095);
        run_scan(1'b0);
        wait_done();

        randomize_pop();
        run_scan(1'b1);
        wait_done();

        // Abort during the third evaluation, then confirm a clean restart.
        randomize_pop();
        base = n_evals;
        run_scan(1'b0);
        k = 0;
        while (n_evals < base + 3 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_idx2_eval", CHROM_W'(n_evals >= base + 3), CHROM_W'(1));
        repeat (5) @(posedge clk);
        #1;
        done_before = n_done;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        check("midrst_busy", CHROM_W'(busy), CHROM_W'(0));
        check("midrst_best_dist", CHROM_W'(best_dist), CHROM_W'(DIST_MAX));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (L + 20) @(posedge clk);
        #1;
        check("midrst_no_done", CHROM_W'(n_done - done_before), CHROM_W'(0));
        randomize_pop();
        run_scan(1'b0);
        wait_done();

        for (int t = 0; t < 8; t++) begin
            randomize_pop();
            run_scan(1'b0);
            wait_done();
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", CHROM_W'(sb.size()), CHROM_W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fitness_select.md
# fitness_select

Selection stage directly downstream of the distance evaluator in the genetic-algorithm datapath. For each generation it walks the population RAM, issues every chromosome to the distance unit (start/done handshake), and tracks the two shortest-tour chromosomes. The resulting parents feed the crossover/mutation stage.

## Interface
- CHROM_W, 150: chromosome width (15 genes x 10 bits)
- DIST_W, 12: tour-distance width from the evaluator
- POP_SIZE, 16: individuals per generation; must be at least 2
- IDX_W, 4: population address width, equal to clog2(POP_SIZE)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a generation scan
- pop_addr  out  IDX_W  population RAM read address
- pop_data  in  CHROM_W  RAM read data, valid 1 cycle after pop_addr
- dist_chrom  out  CHROM_W  chromosome presented to the evaluator
- dist_start  out  1  one-cycle evaluator start pulse
- dist_in  in  DIST_W  evaluator result
- dist_done  in  1  evaluator result valid
- parent_a / parent_b  out  CHROM_W  best / second-best chromosome
- best_dist / second_dist  out  DIST_W  their distances
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the scan completes

## Operation
- States and transitions:
  - IDLE: on start, clear idx to 0, set best_dist and second_dist to all-ones (4095), go to READ.
  - READ: drive pop_addr=idx, go to WAIT_RD.
  - WAIT_RD: go to LATCH.
  - LATCH: register pop_data into dist_chrom, pulse dist_start, go to WAIT_DONE.
  - WAIT_DONE: wait for dist_done, register dist_in, go to UPDATE.
  - UPDATE: apply the insertion rule. If idx==POP_SIZE-1 go to FINISH; else increment idx and go to READ.
  - FINISH: pulse done for 1 cycle, clear busy, go to IDLE.
- Insertion rule:
  - If d < best_dist: second ← best (distance and chromosome), best ← candidate.
  - Else if d < second_dist: second ← candidate.
  - Comparisons are strict and unsigned, so on ties the lower index wins.
- dist_chrom is held stable from dist_start until dist_done.
- Ignored inputs:
  - start while busy.
  - dist_done outside WAIT_DONE.
- Results (parent_*, *_dist) hold after done until the next accepted start. They are not valid while busy.
- Reset values: all outputs 0, except best_dist and second_dist, which reset to all-ones. State resets to IDLE, idx to 0.
- Reset mid-scan aborts immediately. No done pulse is issued. Evaluator state is the evaluator's own concern.

## Timing
- Per individual: 5 cycles + evaluator latency L (dist_start to dist_done).
- Scan: POP_SIZE·(5+L) + 1 cycles from start to done.
- dist_done in the same cycle dist_start is asserted is impossible by construction; only the WAIT_DONE sample counts.
- A start accepted on the cycle after done begins a fresh scan with no stale results.

## Configuration
- SEL_DEDUP_EN defined:
  - A candidate whose chromosome equals the current parent_a is never inserted as second.
  - If it also has d < best_dist, best_dist is replaced but second is kept (no duplicate parents).
- Undefined: no chromosome comparison; duplicates may occupy both parent slots.

## Structure
- Shared package ga_pkg holds:
  - CHROM_W, DIST_W, GENE_W=10.
  - The state enum type.
  - DIST_MAX (all-ones) constant.
- One natural sub-module: best2_tracker, containing the insertion-rule registers and comparators (plus the dedup compare under SEL_DEDUP_EN). The FSM stays in fitness_select.

## Test plan
- POP_SIZE=4, model distances {300,100,200,50}, L=20:
  - Required: parent_a=idx3, best=50; parent_b=idx1, second=100.
  - done exactly 101 cycles after start.
- Tie: distances {100,100,100,100}:
  - Required: parent_a=idx0, parent_b=idx1, both distances 100.
- With SEL_DEDUP_EN:
  - idx0 and idx2 identical with distance 80, idx1 distance 90.
  - Required: parent_b=idx1, second=90.
  - Without the macro: parent_b=idx2.
- Protocol robustness, both together give identical results to an undisturbed scan:
  - start pulsed again mid-scan is ignored.
  - Spurious dist_done during READ is ignored.
- Reset mid-scan:
  - rst_n low during idx=2 WAIT_DONE.
  - Required: busy=0, best_dist=4095, and no done pulse.
  - A subsequent start completes normally.
- All distances 4095:
  - Required: best and second remain 4095 with parents 0, and done still asserts.
